// File: rtl/regbank_access_arbiter.sv
// Arbiter/sequencer for the single-ported 4x8 register bank: accept -> bank cycle -> response.
// Define REGBANK_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module regbank_access_arbiter #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_wr,
    input  logic [2*ADDR_W-1:0]   req_rs,
    input  logic [2*DATA_W-1:0]   req_data,
    output logic [1:0]            req_ready,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  bank_wr,
    output logic [ADDR_W-1:0]     bank_rs,
    output logic [DATA_W-1:0]     bank_data,
    input  logic [DATA_W-1:0]     bank_regval,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [1:0]            fsm_state
);

    // Handshakes: a request transfers in the cycle where req_valid[i] & req_ready[i] are both high;
    // a response transfers in the cycle where resp_valid[i] & resp_ready[i] are both high.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] TO_LAST = (TIMEOUT == 0) ? 4'd0 : 4'(TIMEOUT - 1);

    state_t              state, state_next;
    logic                grant, grant_next;
    logic                wr_l, wr_next;
    logic [ADDR_W-1:0]   rs_l, rs_next;
    logic [DATA_W-1:0]   data_l, data_next;
    logic                issued, issued_next;
    logic [3:0]          cnt, cnt_next;
    logic                g_pick;

    logic [1:0]          req_ready_next;
    logic [1:0]          resp_valid_next;
    logic [DATA_W-1:0]   resp_data_next;
    logic                bank_wr_next;
    logic [ADDR_W-1:0]   bank_rs_next;
    logic [DATA_W-1:0]   bank_data_next;
    logic                busy_next;
    logic                timeout_err_next;

`ifndef REGBANK_ARB_FIXED_PRIO_EN
    logic                rr_ptr, rr_next;
`endif

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        grant_next       = grant;
        wr_next          = wr_l;
        rs_next          = rs_l;
        data_next        = data_l;
        issued_next      = issued;
        cnt_next         = cnt;
        req_ready_next   = 2'b00;
        resp_valid_next  = resp_valid;
        resp_data_next   = resp_data;
        bank_wr_next     = 1'b0;
        bank_rs_next     = bank_rs;
        bank_data_next   = bank_data;
        timeout_err_next = timeout_err;
`ifdef REGBANK_ARB_FIXED_PRIO_EN
        g_pick = ~req_valid[0];
`else
        rr_next = rr_ptr;
        g_pick  = (&req_valid) ? rr_ptr : req_valid[1];
`endif

        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready_next[g_pick] = 1'b1;
                    grant_next  = g_pick;
                    wr_next     = g_pick ? req_wr[1] : req_wr[0];
                    rs_next     = g_pick ? req_rs[2*ADDR_W-1:ADDR_W] : req_rs[ADDR_W-1:0];
                    data_next   = g_pick ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
                    issued_next = 1'b0;
                    state_next  = ACCESS;
`ifndef REGBANK_ARB_FIXED_PRIO_EN
                    rr_next     = ~g_pick;
`endif
                end
            end
            ACCESS: begin
                // First ACCESS cycle loads the bank pins; second one sees the bank's answer.
                if (!issued) begin
                    bank_wr_next   = wr_l;
                    bank_rs_next   = rs_l;
                    bank_data_next = data_l;
                    issued_next    = 1'b1;
                end else begin
                    resp_data_next         = wr_l ? data_l : bank_regval;
                    resp_valid_next        = 2'b00;
                    resp_valid_next[grant] = 1'b1;
                    cnt_next               = 4'd0;
                    state_next             = RESP;
                end
            end
            RESP: begin
                if (resp_ready[grant]) begin
                    resp_valid_next = 2'b00;
                    state_next      = IDLE;
                end else if (TIMEOUT != 0) begin
                    if (cnt == TO_LAST) begin
                        resp_valid_next  = 2'b00;
                        timeout_err_next = 1'b1;
                        state_next       = IDLE;
                    end else begin
                        cnt_next = cnt + 4'd1;
                    end
                end
            end
            default: begin
                resp_valid_next = 2'b00;
                state_next      = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= 1'b0;
            wr_l        <= 1'b0;
            rs_l        <= '0;
            data_l      <= '0;
            issued      <= 1'b0;
            cnt         <= 4'd0;
            req_ready   <= 2'b00;
            resp_valid  <= 2'b00;
            resp_data   <= '0;
            bank_wr     <= 1'b0;
            bank_rs     <= '0;
            bank_data   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            grant       <= grant_next;
            wr_l        <= wr_next;
            rs_l        <= rs_next;
            data_l      <= data_next;
            issued      <= issued_next;
            cnt         <= cnt_next;
            req_ready   <= req_ready_next;
            resp_valid  <= resp_valid_next;
            resp_data   <= resp_data_next;
            bank_wr     <= bank_wr_next;
            bank_rs     <= bank_rs_next;
            bank_data   <= bank_data_next;
            busy        <= busy_next;
            timeout_err <= timeout_err_next;
        end
    end

`ifndef REGBANK_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else begin
            rr_ptr <= rr_next;
        end
    end
`endif

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Directed bench for regbank_access_arbiter with a behavioural 4x8 bank model.
module tb_regbank_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_wr = '0;
    logic [3:0] req_rs = '0;
    logic [15:0] req_data = '0;
    logic [1:0] req_ready;
    logic [1:0] resp_valid;
    logic [1:0] resp_ready = '0;
    logic [7:0] resp_data;
    logic       bank_wr;
    logic [1:0] bank_rs;
    logic [7:0] bank_data;
    logic [7:0] bank_regval;
    logic       busy;
    logic       timeout_err;
    logic [1:0] fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];
    logic [7:0] bank_mem[4];

    typedef struct {
        logic       id;
        logic       wr;
        logic [1:0] rs;
        logic [7:0] data;
        logic [7:0] exp_d;
    } vec_t;
    vec_t vecs[9];

    regbank_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_rs(req_rs), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .bank_wr(bank_wr), .bank_rs(bank_rs), .bank_data(bank_data),
        .bank_regval(bank_regval), .busy(busy), .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) bank_mem[i] = 8'h00;
    end
    always @(posedge clk) if (bank_wr) bank_mem[bank_rs] <= bank_data;
    assign bank_regval = bank_mem[bank_rs];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One full access with fixed-latency checks at every stage.
    task automatic access(input logic id, input logic wr, input logic [1:0] rs,
                          input logic [7:0] data, input logic [7:0] exp_d);
        logic [1:0] oh;
        oh = id ? 2'b10 : 2'b01;
        @(negedge clk);
        req_valid = oh;
        req_wr    = {wr, wr};
        req_rs    = {rs, rs};
        req_data  = {data, data};
        @(negedge clk);
        chk("req_ready", req_ready, oh);
        chk("busy_accept", busy, 1);
        req_valid = 2'b00;
        @(negedge clk);
        chk("bank_wr", bank_wr, wr);
        chk("bank_rs", bank_rs, rs);
        if (wr) chk("bank_data", bank_data, data);
        chk("resp_early", resp_valid, 2'b00);
        @(negedge clk);
        chk("resp_valid", resp_valid, oh);
        chk("resp_data", resp_data, exp_d);
        chk("bank_wr_resp", bank_wr, 0);
        resp_ready = oh;
        @(negedge clk);
        chk("resp_clear", resp_valid, 2'b00);
        chk("busy_idle", busy, 0);
        resp_ready = 2'b00;
    endtask

    initial begin
        int got;
        int hi;
        vecs[0] = '{1'b0, 1'b1, 2'd2, 8'hA5, 8'hA5};
        vecs[1] = '{1'b0, 1'b0, 2'd2, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 2'd0, 8'h3C, 8'h3C};
        vecs[3] = '{1'b1, 1'b1, 2'd3, 8'hFF, 8'hFF};
        vecs[4] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h3C};
        vecs[5] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'hFF};
        vecs[6] = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h00};
        vecs[8] = '{1'b1, 1'b0, 2'd2, 8'h00, 8'hA5};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_bank_wr", bank_wr, 0);
        chk("rst_bank_rs", bank_rs, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_state", fsm_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            access(vecs[i].id, vecs[i].wr, vecs[i].rs, vecs[i].data, vecs[i].exp_d);
        end

        // both requesters valid every cycle: grant sequence
`ifdef REGBANK_ARB_FIXED_PRIO_EN
        exp_q = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        @(negedge clk);
        req_valid = 2'b11;
        req_wr = 2'b00;
        req_rs = 4'b1010;
        resp_ready = 2'b11;
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                chk("rr_grant", req_ready, exp_q.pop_front());
                got++;
            end
        end
        chk("rr_grant_count", got, 4);
        req_valid = 2'b00;
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        chk("rr_drain_idle", busy, 0);
        resp_ready = 2'b00;
        chk("timeout_err_before", timeout_err, 0);

        // response timeout, with non-granted resp_ready ignored
        @(negedge clk);
        req_valid = 2'b01;
        req_wr = 2'b00;
        req_rs = 4'b0000;
        @(negedge clk);
        chk("to_req_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        @(negedge clk);
        resp_ready = 2'b10;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i < 3) chk("other_ready_ignored", resp_valid, 2'b01);
            if (i == 0) chk("to_resp_data", resp_data, 8'h3C);
            if (resp_valid[0]) hi++;
            if (i == 2) resp_ready = 2'b00;
        end
        chk("to_resp_cycles", hi, 15);
        chk("to_resp_valid", resp_valid, 0);
        chk("to_err", timeout_err, 1);
        chk("to_idle", busy, 0);
        access(1'b1, 1'b0, 2'd2, 8'h00, 8'hA5);
        chk("to_err_sticky", timeout_err, 1);

        // async reset during the bank cycle abandons the write
        @(negedge clk);
        req_valid = 2'b01;
        req_wr = 2'b11;
        req_rs = 4'b1111;
        req_data = 16'h7777;
        @(negedge clk);
        chk("ar_req_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        @(negedge clk);
        chk("ar_bank_wr_pre", bank_wr, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_bank_wr", bank_wr, 0);
        chk("ar_resp_valid", resp_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_state", fsm_state, 0);
        chk("ar_timeout_err", timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 1'b0, 2'd3, 8'h00, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
